// File: rtl/spi_burst_sequencer.sv
// spi_burst_sequencer: host-side burst engine for spi_master.
// Streams N TX bytes over the shared data bus with wr/buffempty, pulls each
// received byte with rd/charreceived into a small RX FIFO, and only issues a
// write when the FIFO has room for every byte already in flight.
module spi_burst_sequencer #(
    parameter int WORD_LEN = 8,
    parameter int LEN_W    = 8,
    parameter int RX_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    input  logic [WORD_LEN-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [WORD_LEN-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                busy,
    output logic                done,
    output logic                err,
    inout  wire  [WORD_LEN-1:0] spi_data,
    output logic                spi_wr,
    output logic                spi_rd,
    input  logic                spi_buffempty,
    input  logic                spi_charreceived,
    input  logic                spi_senderr,
    output logic                spi_res_senderr
);

    localparam int PTR_W = $clog2(RX_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RX_DEPTH);

    typedef enum logic [2:0] {IDLE, ARB, WR, RD_TURN, RD, FIN} state_t;

    state_t              state;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    sent;
    logic [LEN_W-1:0]    recv;
    logic [LEN_W-1:0]    inflight;
    logic [WORD_LEN-1:0] wr_data;
    logic                drive;
    logic                senderr_seen;

    logic [WORD_LEN-1:0] mem [RX_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    free_slots;
    logic                fifo_full;
    logic                credit_ok;
    logic                push;
    logic                pop;

    // Bytes written to the master but not yet pulled back (0..2).
    assign inflight   = sent - recv;
    assign fifo_full  = (count == DEPTH_C);
    assign free_slots = DEPTH_C - count;
    // A new write is allowed only if every in-flight byte plus this one fits.
    assign credit_ok  = ({{(LEN_W + 1){1'b0}}, free_slots} >
                         {{(CNT_W + 1){1'b0}}, inflight});

    assign push     = (state == RD);
    assign pop      = rx_ready && rx_valid;
    assign rx_valid = (count != '0);
    assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

    // Bus is driven only during the WR cycle; released in RD_TURN and RD.
    assign spi_data = drive ? wr_data : {WORD_LEN{1'bz}};

    // Burst FSM with registered strobes, plus send-error capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            tx_ready        <= 1'b0;
            spi_wr          <= 1'b0;
            spi_rd          <= 1'b0;
            spi_res_senderr <= 1'b0;
            drive           <= 1'b0;
            wr_data         <= '0;
            len_q           <= '0;
            sent            <= '0;
            recv            <= '0;
            senderr_seen    <= 1'b0;
        end else begin
            done     <= 1'b0;
            tx_ready <= 1'b0;
            spi_wr   <= 1'b0;
            spi_rd   <= 1'b0;
            drive    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sent <= '0;
                        recv <= '0;
                        err  <= 1'b0;
                        if (len == '0) begin
                            state <= FIN;
                        end else begin
                            len_q <= len;
                            busy  <= 1'b1;
                            state <= ARB;
                        end
                    end
                end
                ARB: begin
                    if (spi_charreceived && !fifo_full) begin
                        state <= RD_TURN;
                    end else if (recv == len_q) begin
                        state <= FIN;
                    end else if (sent < len_q && spi_buffempty && tx_valid && credit_ok) begin
                        state    <= WR;
                        spi_wr   <= 1'b1;
                        tx_ready <= 1'b1;
                        drive    <= 1'b1;
                        wr_data  <= tx_data;
                        sent     <= sent + 1'b1;
                    end
                end
                WR:      state <= ARB;
                RD_TURN: begin
                    spi_rd <= 1'b1;
                    state  <= RD;
                end
                RD: begin
                    recv  <= recv + 1'b1;
                    state <= ARB;
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // One clear pulse per senderr episode; re-armed once it drops.
            if (spi_senderr && !senderr_seen) begin
                err             <= 1'b1;
                spi_res_senderr <= 1'b1;
                senderr_seen    <= 1'b1;
            end else begin
                spi_res_senderr <= 1'b0;
            end
            if (!spi_senderr) senderr_seen <= 1'b0;
        end
    end

    // RX FIFO pointers and occupancy; simultaneous push and pop keeps count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // RX FIFO storage; byte captured from the bus at the end of the RD cycle.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= spi_data;
    end

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Bench for spi_burst_sequencer: a table of burst scenarios plus randomized
// bursts, checked against the expected byte streams, alongside a simple
// double-buffered spi_master model that answers each written byte.
module tb_spi_burst_sequencer;
    localparam int D = 4;
    localparam logic [7:0] IDLE_BUS = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy, done, err;
    wire  [7:0] spi_data;
    logic       spi_wr, spi_rd, spi_buffempty, spi_charreceived;
    logic       spi_senderr, spi_res_senderr;

    spi_burst_sequencer #(.WORD_LEN(8), .LEN_W(8), .RX_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .done(done), .err(err),
        .spi_data(spi_data), .spi_wr(spi_wr), .spi_rd(spi_rd),
        .spi_buffempty(spi_buffempty), .spi_charreceived(spi_charreceived),
        .spi_senderr(spi_senderr), .spi_res_senderr(spi_res_senderr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    // Stimulus data and host/slave control
    logic [7:0] tx_arr [64];
    logic [7:0] resp_arr [64];
    int tx_n = 0;
    bit gap_en = 0;
    bit rx_force_low = 0;
    int sh_len = 3;

    // spi_master model: one-byte TX buffer feeding a shifter; the received
    // byte waits in a holding register until read.
    logic buf_full, sh_busy, cr;
    logic [7:0] cr_byte;
    int sh_cnt, resp_idx;

    assign spi_buffempty    = !buf_full;
    assign spi_charreceived = cr;
    assign spi_data = spi_rd ? cr_byte : (spi_wr ? 8'bzzzzzzzz : IDLE_BUS);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full <= 0; sh_busy <= 0; sh_cnt <= 0; cr <= 0; cr_byte <= 0; resp_idx <= 0;
        end else begin
            if (start && !busy) resp_idx <= 0;
            if (!sh_busy && buf_full) begin
                sh_busy <= 1; sh_cnt <= sh_len; buf_full <= 0;
            end
            if (spi_wr) buf_full <= 1;
            if (sh_busy) begin
                if (sh_cnt > 0) sh_cnt <= sh_cnt - 1;
                else if (!cr) begin
                    cr <= 1; cr_byte <= resp_arr[resp_idx]; resp_idx <= resp_idx + 1; sh_busy <= 0;
                end
            end
            if (spi_rd) cr <= 0;
        end
    end

    // Host driver and bus/FIFO monitor, evaluated away from the active edge.
    logic [7:0] wr_log[$];
    logic [7:0] rx_log[$];
    int tx_idx = 0, occ = 0, rd_cnt = 0, done_cnt = 0, res_cnt = 0, viol = 0;
    bit prev_wr = 0;

    always @(negedge clk) begin
        bit p;
        if (rst) begin
            tx_idx = 0; tx_valid = 0; rx_ready = 0; occ = 0; prev_wr = 0;
        end else begin
            if (start && !busy) begin
                tx_idx = 0;
                wr_log.delete(); rx_log.delete();
                done_cnt = 0; res_cnt = 0; rd_cnt = 0;
            end else if (tx_ready) tx_idx++;
            tx_valid = (tx_idx < tx_n) && (!gap_en || $urandom_range(3) != 0);
            tx_data  = tx_arr[tx_idx % 64];
            rx_ready = rx_force_low ? 1'b0 : (!gap_en || $urandom_range(2) != 0);

            if (spi_wr) begin
                wr_log.push_back(spi_data);
                if (!spi_buffempty || prev_wr) viol++;
            end
            if (spi_rd) begin
                rd_cnt++;
                if (spi_data !== cr_byte) viol++;
                if (occ == D) viol++;
            end
            if (!spi_wr && !spi_rd && spi_data !== IDLE_BUS) viol++;
            if (rx_valid !== (occ != 0)) viol++;
            p = rx_valid && rx_ready;
            if (p) rx_log.push_back(rx_data);
            occ = occ + (spi_rd ? 1 : 0) - (p ? 1 : 0);
            if (done) done_cnt++;
            if (spi_res_senderr) res_cnt++;
            prev_wr = spi_wr;
        end
    end

    typedef struct {
        int len;
        int hold;       // cycles rx_ready held low from start (0 = none)
        int serr;       // cycle offset to raise spi_senderr for 5 cycles (-1 = none)
        bit gaps;
        bit poke;       // pulse start mid-burst (must be ignored)
        bit fixed;      // use the 55/AA/55 -> FF/00/FF pattern
        int exp_stall;  // writes and FIFO occupancy expected while stalled
        bit exp_err;
        int exp_res;
    } vec_t;

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            tx_arr[i]   = 8'($urandom);
            resp_arr[i] = 8'($urandom);
        end
    endtask

    task automatic run_burst(input vec_t v);
        int t;
        bit fin;
        tx_n = v.len; gap_en = v.gaps; rx_force_low = (v.hold > 0);
        start = 1; len = 8'(v.len);
        cyc;
        start = 0;
        chk("start_err_clear", int'(err), 0);
        chk("start_busy", int'(busy), 1);
        t = 0; fin = 0;
        while (!fin && t < 4000) begin
            cyc; t++;
            if (v.poke && t == 3) begin start = 1; len = 8'd1; end
            if (v.poke && t == 4) start = 0;
            if (t == v.serr) spi_senderr = 1;
            if (t == v.serr + 5) spi_senderr = 0;
            if (v.hold > 0 && t == v.hold) begin
                chk("stall_writes", wr_log.size(), v.exp_stall);
                chk("stall_occupancy", occ, v.exp_stall);
                rx_force_low = 0;
            end
            if (done_cnt > 0) fin = 1;
        end
        chk("done_seen", int'(fin), 1);
        t = 0;
        while ((rx_valid || busy) && t < 500) begin cyc; t++; end
        cyc; cyc;
        chk("done_count", done_cnt, 1);
        chk("busy_end", int'(busy), 0);
        chk("err_end", int'(err), int'(v.exp_err));
        chk("res_senderr_pulses", res_cnt, v.exp_res);
        chk("wr_count", wr_log.size(), v.len);
        for (int i = 0; i < v.len && i < wr_log.size(); i++)
            chk("wr_byte", int'(wr_log[i]), int'(tx_arr[i]));
        chk("rx_count", rx_log.size(), v.len);
        for (int i = 0; i < v.len && i < rx_log.size(); i++)
            chk("rx_byte", int'(rx_log[i]), int'(resp_arr[i]));
        chk("bus_violations", viol, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[5];
        vec_t rv;
        int t, n;
        vt[0] = '{len: 3, hold: 0,  serr: -1, gaps: 0, poke: 0, fixed: 1, exp_stall: 0, exp_err: 0, exp_res: 0};
        vt[1] = '{len: 8, hold: 60, serr: -1, gaps: 0, poke: 0, fixed: 0, exp_stall: 4, exp_err: 0, exp_res: 0};
        vt[2] = '{len: 6, hold: 0,  serr: 8,  gaps: 0, poke: 0, fixed: 0, exp_stall: 0, exp_err: 1, exp_res: 1};
        vt[3] = '{len: 5, hold: 50, serr: -1, gaps: 0, poke: 0, fixed: 0, exp_stall: 4, exp_err: 0, exp_res: 0};
        vt[4] = '{len: 12, hold: 0, serr: -1, gaps: 1, poke: 1, fixed: 0, exp_stall: 0, exp_err: 0, exp_res: 0};

        rst = 1; start = 0; len = 0; spi_senderr = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_spi_wr", int'(spi_wr), 0);
        chk("rst_spi_rd", int'(spi_rd), 0);
        chk("rst_tx_ready", int'(tx_ready), 0);
        chk("rst_bus_released", int'(spi_data), int'(IDLE_BUS));
        rst = 0;
        cyc;

        // Scenario table
        for (int k = 0; k < 5; k++) begin
            if (vt[k].fixed) begin
                tx_arr[0] = 8'h55; tx_arr[1] = 8'hAA; tx_arr[2] = 8'h55;
                resp_arr[0] = 8'hFF; resp_arr[1] = 8'h00; resp_arr[2] = 8'hFF;
            end else fill_random(vt[k].len);
            sh_len = 3;
            run_burst(vt[k]);
        end

        // Zero-length burst: done two cycles after start, no bus traffic
        tx_n = 0; gap_en = 0;
        start = 1; len = 0;
        cyc; start = 0;
        chk("len0_done_early", int'(done), 0);
        cyc;
        chk("len0_done", int'(done), 1);
        chk("len0_busy", int'(busy), 0);
        cyc;
        chk("len0_done_end", int'(done), 0);
        chk("len0_writes", wr_log.size(), 0);
        chk("len0_reads", rd_cnt, 0);

        // Reset with two bytes in flight
        fill_random(6); tx_n = 6; sh_len = 4;
        start = 1; len = 8'd6;
        cyc; start = 0;
        t = 0;
        while ((wr_log.size() - rd_cnt) != 2 && t < 200) begin cyc; t++; end
        chk("inflight_two", wr_log.size() - rd_cnt, 2);
        rst = 1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_spi_wr", int'(spi_wr), 0);
        chk("arst_tx_ready", int'(tx_ready), 0);
        chk("arst_rx_valid", int'(rx_valid), 0);
        chk("arst_rx_data", int'(rx_data), 0);
        chk("arst_bus_released", int'(spi_data), int'(IDLE_BUS));
        cyc; cyc;
        rst = 0;
        cyc; cyc; cyc;
        chk("arst_no_done", done_cnt, 0);
        fill_random(2);
        rv = '{len: 2, hold: 0, serr: -1, gaps: 0, poke: 0, fixed: 0, exp_stall: 0, exp_err: 0, exp_res: 0};
        run_burst(rv);

        // Randomized bursts
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 14);
            fill_random(n);
            sh_len = $urandom_range(1, 6);
            rv = '{len: n, hold: 0, serr: -1, gaps: 1, poke: 0, fixed: 0, exp_stall: 0, exp_err: 0, exp_res: 0};
            run_burst(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
